gpio_port: RTL and testbench

Parametrised parallel-output port for the CPU core's memory-mapped I/O. A bus write with EN high updates a packed register holding the GPIO field, LED field and counter-select field. Each write applies one of four modes: write, bit-set, bit-clear or bit-toggle. The block adds:
- a per-LED blink mask driven by a shared prescaler
- registered readback
- a one-cycle strobe whenever the counter-select field changes

---
 rtl/gpio_port.sv | 97 +++++++++
 tb/tb_gpio_port.sv | 129 ++++++++++++
 2 files changed

// File: rtl/gpio_port.sv
// Memory-mapped parallel output port: packed {GPIO, LED, CS} register with
// write/set/clear/toggle modes, LED blink mask, registered readback and CS-change strobe.
module gpio_port #(
    parameter int                 LED_W     = 8,
    parameter int                 CS_W      = 2,
    parameter int                 GPIO_W    = 22,
    parameter logic [LED_W-1:0]   LED_RST   = 8'h2A,
    parameter int                 BLINK_DIV = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              EN,
    input  logic              SEL,
    input  logic [1:0]        WMODE,
    input  logic [31:0]       PData_in,
    output logic [31:0]       PData_out,
    output logic [CS_W-1:0]   counter_set,
    output logic [LED_W-1:0]  LED_out,
    output logic [GPIO_W-1:0] GPIOf0,
    output logic              cs_changed
);

    localparam logic [31:0] R_RST = {{GPIO_W{1'b0}}, LED_RST, {CS_W{1'b0}}};

    generate
        if (LED_W + CS_W + GPIO_W != 32) begin : g_width_check
            $error("gpio_port: LED_W + CS_W + GPIO_W must equal 32");
        end
    endgenerate

    logic [31:0]          r_q, r_next;
    logic [LED_W-1:0]     m_q, m_next;
    logic [LED_W-1:0]     d_led;
    logic [31:0]          m_word;
    logic [BLINK_DIV-1:0] cnt_q;
    logic                 phase_q;

    assign d_led = PData_in[CS_W +: LED_W];

    always_comb begin
        r_next = r_q;
        m_next = m_q;
        if (EN) begin
            if (!SEL) begin
                case (WMODE)
                    2'b00:   r_next = PData_in;
                    2'b01:   r_next = r_q | PData_in;
                    2'b10:   r_next = r_q & ~PData_in;
                    default: r_next = r_q ^ PData_in;
                endcase
            end else begin
                case (WMODE)
                    2'b00:   m_next = d_led;
                    2'b01:   m_next = m_q | d_led;
                    2'b10:   m_next = m_q & ~d_led;
                    default: m_next = m_q ^ d_led;
                endcase
            end
        end
    end

    // Readback view of the mask sits at the LED bit position.
    always_comb begin
        m_word = '0;
        m_word[CS_W +: LED_W] = m_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q        <= R_RST;
            m_q        <= '0;
            cnt_q      <= '0;
            phase_q    <= 1'b0;
            PData_out  <= '0;
            cs_changed <= 1'b0;
        end else begin
            r_q        <= r_next;
            m_q        <= m_next;
            PData_out  <= SEL ? m_word : r_next;
            cs_changed <= (r_next[CS_W-1:0] != r_q[CS_W-1:0]);
            // A mask write restarts the blink phase so all LEDs start in sync.
            if (EN && SEL) begin
                cnt_q   <= '0;
                phase_q <= 1'b0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
                if (cnt_q == '1)
                    phase_q <= ~phase_q;
            end
        end
    end

    assign counter_set = r_q[CS_W-1:0];
    assign GPIOf0      = r_q[31:CS_W+LED_W];
    assign LED_out     = r_q[CS_W +: LED_W] ^ (m_q & {LED_W{phase_q}});

endmodule

// File: tb/tb_gpio_port.sv
// Directed self-checking bench for gpio_port, built with a short blink prescaler.
module tb_gpio_port;

    logic        clk = 1'b0;
    logic        rst, en, sel;
    logic [1:0]  wmode;
    logic [31:0] pdata_in, pdata_out;
    logic [1:0]  counter_set;
    logic [7:0]  led_out;
    logic [21:0] gpio;
    logic        cs_changed;

    int total = 0;
    int bad   = 0;

    gpio_port #(.LED_W(8), .CS_W(2), .GPIO_W(22), .LED_RST(8'h2A), .BLINK_DIV(3)) dut (
        .clk(clk), .rst(rst), .EN(en), .SEL(sel), .WMODE(wmode),
        .PData_in(pdata_in), .PData_out(pdata_out), .counter_set(counter_set),
        .LED_out(led_out), .GPIOf0(gpio), .cs_changed(cs_changed)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic s, input logic [1:0] m, input logic [31:0] d);
        en = 1'b1; sel = s; wmode = m; pdata_in = d;
        tick();
        en = 1'b0; sel = 1'b0; wmode = 2'b00; pdata_in = '0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; sel = 1'b0; wmode = 2'b00; pdata_in = '0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_led", {24'd0, led_out}, 32'h2A);
        chk("rst_cs", {30'd0, counter_set}, 32'h0);
        chk("rst_gpio", {10'd0, gpio}, 32'h0);
        chk("rst_pdata", pdata_out, 32'h0);
        chk("rst_csch", {31'd0, cs_changed}, 32'h0);

        wr(1'b0, 2'b00, 32'h0000_0155);
        chk("wr_led", {24'd0, led_out}, 32'h55);
        chk("wr_cs", {30'd0, counter_set}, 32'h1);
        chk("wr_gpio", {10'd0, gpio}, 32'h0);
        chk("wr_csch", {31'd0, cs_changed}, 32'h1);
        chk("wr_pdata", pdata_out, 32'h0000_0155);
        tick();
        chk("wr_csch_drop", {31'd0, cs_changed}, 32'h0);

        // set / clear / toggle back to back
        en = 1'b1; sel = 1'b0; wmode = 2'b01; pdata_in = 32'h8000_0002;
        tick();
        chk("set_pdata", pdata_out, 32'h8000_0157);
        chk("set_gpio21", {31'd0, gpio[21]}, 32'h1);
        chk("set_cs", {30'd0, counter_set}, 32'h3);
        chk("set_csch", {31'd0, cs_changed}, 32'h1);
        wmode = 2'b10; pdata_in = 32'h0000_0004;
        tick();
        chk("clr_pdata", pdata_out, 32'h8000_0153);
        chk("clr_csch", {31'd0, cs_changed}, 32'h0);
        wmode = 2'b11; pdata_in = 32'h0000_03FC;
        tick();
        en = 1'b0; wmode = 2'b00; pdata_in = '0;
        chk("tgl_pdata", pdata_out, 32'h8000_02AF);
        chk("tgl_led", {24'd0, led_out}, 32'hAB);
        chk("tgl_csch", {31'd0, cs_changed}, 32'h0);

        // same CS value twice: pulse only after the first
        wr(1'b0, 2'b00, 32'h0000_0155);
        chk("same1_csch", {31'd0, cs_changed}, 32'h1);
        wr(1'b0, 2'b00, 32'h0000_0155);
        chk("same2_csch", {31'd0, cs_changed}, 32'h0);

        // blink: LED = 2A, mask = 0F
        wr(1'b0, 2'b00, 32'h0000_00A8);
        chk("blk_led0", {24'd0, led_out}, 32'h2A);
        wr(1'b1, 2'b00, 32'h0000_003C);
        chk("blk_mask_rd", pdata_out, 32'h0000_003C);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("blk_off%0d", i), {24'd0, led_out}, 32'h2A);
            tick();
        end
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("blk_on%0d", i), {24'd0, led_out}, 32'h25);
            tick();
        end
        chk("blk_off_again", {24'd0, led_out}, 32'h2A);
        chk("blk_main_rd", pdata_out, 32'h0000_00A8);

        // mid-period mask rewrite restarts the 8-cycle count
        tick(); tick(); tick(); tick();
        wr(1'b1, 2'b01, 32'h0000_003C);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("rst_blk_off%0d", i), {24'd0, led_out}, 32'h2A);
            tick();
        end
        chk("rst_blk_on", {24'd0, led_out}, 32'h25);

        // reset while blinking with R off its reset value and a write pending
        wr(1'b0, 2'b01, 32'h8000_0001);
        chk("pre_rst_cs", {30'd0, counter_set}, 32'h1);
        rst = 1'b1; en = 1'b1; sel = 1'b0; wmode = 2'b00; pdata_in = 32'hFFFF_FFFF;
        tick();
        rst = 1'b0; en = 1'b0; pdata_in = '0;
        chk("mrst_led", {24'd0, led_out}, 32'h2A);
        chk("mrst_cs", {30'd0, counter_set}, 32'h0);
        chk("mrst_gpio", {10'd0, gpio}, 32'h0);
        chk("mrst_pdata", pdata_out, 32'h0);
        chk("mrst_csch", {31'd0, cs_changed}, 32'h0);
        for (int i = 0; i < 10; i++) tick();
        chk("mrst_mask_clear", {24'd0, led_out}, 32'h2A);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
